// File: rtl/reg_file_pkg.sv
// reg_file shared definitions.
// Address-width helper and the CPU's default bank shape.
package reg_file_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int CPU_DEPTH = 32;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// reg_file access bus: one write port, two read ports.
// The master drives addresses and data; the slave returns reads and WERR.
interface reg_file_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);

  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [WIDTH-1:0]  WDATA;
  logic [ADDR_W-1:0] RADDR_A;
  logic [WIDTH-1:0]  RDATA_A;
  logic [ADDR_W-1:0] RADDR_B;
  logic [WIDTH-1:0]  RDATA_B;
  logic              WERR;

  modport master (
    output WE, WADDR, WDATA,
    output RADDR_A, RADDR_B,
    input  RDATA_A, RDATA_B, WERR
  );

  modport slave (
    input  WE, WADDR, WDATA,
    input  RADDR_A, RADDR_B,
    output RDATA_A, RDATA_B, WERR
  );

endinterface

// File: rtl/reg_file_d_register.sv
// d_register: one edge-triggered, enable-gated word.
// Synchronous reset to RESET_VAL wins over En.
module d_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= RESET_VAL;
    end else if (En) begin
      r_q <= D;
    end
  end

  assign Q    = r_q;
  assign Qbar = ~r_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register bank, 1 write / 2 async reads.
// Optional hard-wired zero register and write-to-read bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter int               ZERO_REG0 = 1,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  reg_file_if.slave    bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam bit Z0 = (ZERO_REG0 != 0);
  localparam bit BP = (BYPASS != 0);

  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] w_qbar_unused [DEPTH];
  logic             w_discard;
  logic             w_we_ok;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             r_werr;

  function automatic logic in_range(
    input logic [ADDR_W-1:0] a
  );
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return Z0 && (a == '0);
  endfunction

  assign w_discard = bus.WE &&
    (!in_range(bus.WADDR) || is_zero(bus.WADDR));

  // Only a write that will actually land may update or forward.
  assign w_we_ok = bus.WE && !RST && !w_discard;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (Z0 && gi == 0) begin : g_zero
        assign w_q[gi]           = '0;
        assign w_qbar_unused[gi] = '1;
      end else begin : g_word
        logic w_en;
        assign w_en = w_we_ok &&
          (bus.WADDR == ADDR_W'(gi));
        d_register #(
          .WIDTH     (WIDTH),
          .RESET_VAL (RESET_VAL)
        ) u_reg (
          .CLK  (CLK),
          .RST  (RST),
          .En   (w_en),
          .D    (bus.WDATA),
          .Q    (w_q[gi]),
          .Qbar (w_qbar_unused[gi])
        );
      end
    end
  endgenerate

  function automatic logic [WIDTH-1:0] rd_mux(
    input logic [ADDR_W-1:0] a,
    input logic              we_ok,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd,
    input logic [WIDTH-1:0]  q [DEPTH]
  );
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) v = q[i];
    end
    if (!in_range(a) || is_zero(a)) begin
      v = '0;
    end else if (BP && we_ok && (wa == a)) begin
      v = wd;
    end
    return v;
  endfunction

  always_comb begin
    w_rd_a = rd_mux(bus.RADDR_A, w_we_ok,
                    bus.WADDR, bus.WDATA, w_q);
    w_rd_b = rd_mux(bus.RADDR_B, w_we_ok,
                    bus.WADDR, bus.WDATA, w_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_werr <= 1'b0;
    end else begin
      r_werr <= w_discard;
    end
  end

  assign bus.RDATA_A = w_rd_a;
  assign bus.RDATA_B = w_rd_b;
  assign bus.WERR    = r_werr;

endmodule
